// File: rtl/prog_clock_divider.sv
// Programmable clock divider: r_clk with a divide ratio latched once per period, plus a wrap tick and a clamp flag.
// Optional build macro ODD_DUTY50_EN adds a falling-edge flop that makes odd ratios exactly 50% duty.
module prog_clock_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             r_clk,
    output logic             tick,
    output logic             ratio_err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);

    // Ratios below two cannot produce a clock; they are forced to the fastest legal ratio.
    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] ratio);
        logic [CNT_W-1:0] res;
        if (ratio < MIN_DIV) begin
            res = MIN_DIV;
        end else begin
            res = ratio;
        end
        return res;
    endfunction

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_d;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_act_d;
    logic             r_clk_q;
    logic             r_clk_d;
    logic             tick_q;
    logic             tick_d;
    logic             ratio_err_q;
    logic             ratio_err_d;
    logic             wrap_s;

    // Next-state: count, wrap and resample the ratio only at the period boundary.
    always_comb begin
        counter_d   = counter;
        n_act_d     = n_act;
        r_clk_d     = r_clk_q;
        tick_d      = 1'b0;
        ratio_err_d = ratio_err_q;
        // >= rather than == so a corrupted counter still recovers at the next edge
        wrap_s      = (counter >= (n_act - ONE));
        if (en) begin
            if (wrap_s) begin
                counter_d   = ZERO;
                n_act_d     = clamp_ratio(div_ratio);
                ratio_err_d = (div_ratio < MIN_DIV);
                tick_d      = 1'b1;
            end else begin
                counter_d   = counter + ONE;
            end
            r_clk_d = (counter_d < (n_act_d >> 1));
        end else begin
            counter_d   = counter;
            n_act_d     = n_act;
            r_clk_d     = r_clk_q;
            ratio_err_d = ratio_err_q;
        end
    end

    // State registers; reset parks the counter one step before the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter     <= CNT_RST;
            n_act       <= DIV_RST;
            r_clk_q     <= 1'b0;
            tick_q      <= 1'b0;
            ratio_err_q <= 1'b0;
        end else begin
            counter     <= counter_d;
            n_act       <= n_act_d;
            r_clk_q     <= r_clk_d;
            tick_q      <= tick_d;
            ratio_err_q <= ratio_err_d;
        end
    end

`ifdef ODD_DUTY50_EN
    logic r_clk_neg_q;
    logic r_clk_neg_d;

    // Half-cycle copy of the high phase; frozen together with the rest while disabled.
    always_comb begin
        if (en) begin
            r_clk_neg_d = r_clk_q;
        end else begin
            r_clk_neg_d = r_clk_neg_q;
        end
    end

    // Falling-edge register stretching odd-ratio high phases by half a clk period.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_neg_q <= 1'b0;
        end else begin
            r_clk_neg_q <= r_clk_neg_d;
        end
    end

    assign r_clk = n_act[0] ? (r_clk_q | r_clk_neg_q) : r_clk_q;
`else
    assign r_clk = r_clk_q;
`endif

    assign tick      = tick_q;
    assign ratio_err = ratio_err_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: table of ratio segments, period scoreboard measured in half clk cycles.
module tb_prog_clock_divider;

`ifdef ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div_ratio;
    logic       r_clk;
    logic       tick;
    logic       ratio_err;

    prog_clock_divider #(.CNT_W(8), .DEFAULT_DIV(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_ratio (div_ratio),
        .r_clk     (r_clk),
        .tick      (tick),
        .ratio_err (ratio_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div;
        int periods;
        int nact;
        int hi;
        int lo;
        int err;
    } vec_t;

    typedef struct {
        int hi;
        int lo;
        int err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int hi, input int lo, input int err);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        @(negedge clk);
        while (tick !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({"tick_seen_", tag}, int'(tick), 1);
    endtask

    task automatic wait_counter(input int v, input string tag);
        int n = 0;
        @(negedge clk);
        while (int'(dut.counter) != v && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({"counter_reached_", tag}, int'(dut.counter), v);
    endtask

    // Period monitor: samples 2 ns after every clk edge and scores each completed r_clk period.
    int hi_c, lo_c, tk_c, err_c;
    bit have_period = 1'b0;
    bit prev_r = 1'b0;
    always @(posedge clk or negedge clk) begin
        #2;
        if (!mon_en) begin
            have_period = 1'b0;
            prev_r      = r_clk;
        end else begin
            if (r_clk && !prev_r) begin
                if (have_period) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 0, 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("period_high_halves", hi_c, e.hi);
                        check("period_low_halves", lo_c, e.lo);
                        check("period_ratio_err", err_c, e.err);
                        check("period_tick_halves", tk_c, 2);
                    end
                end
                have_period = 1'b1;
                hi_c  = 1;
                lo_c  = 0;
                tk_c  = int'(tick);
                err_c = int'(ratio_err);
            end else begin
                if (r_clk) hi_c++;
                else lo_c++;
                tk_c += int'(tick);
            end
            prev_r = r_clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int hcount;
        vecs[0] = '{4,   3, 4,   4,                 4,                 0};
        vecs[1] = '{5,   2, 5,   ODD50 ? 5 : 4,     ODD50 ? 5 : 6,     0};
        vecs[2] = '{1,   3, 2,   2,                 2,                 1};
        vecs[3] = '{6,   2, 6,   6,                 6,                 0};
        vecs[4] = '{0,   1, 2,   2,                 2,                 1};
        vecs[5] = '{7,   2, 7,   ODD50 ? 7 : 6,     ODD50 ? 7 : 8,     0};
        vecs[6] = '{2,   2, 2,   2,                 2,                 0};
        vecs[7] = '{255, 1, 255, ODD50 ? 255 : 254, ODD50 ? 255 : 256, 0};
        vecs[8] = '{3,   2, 3,   ODD50 ? 3 : 2,     ODD50 ? 3 : 4,     0};
        vecs[9] = '{10,  1, 10,  10,                10,                0};

        rst       = 1'b0;
        en        = 1'b0;
        div_ratio = 8'd10;
        repeat (3) @(negedge clk);
        check("rst_r_clk", int'(r_clk), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_ratio_err", int'(ratio_err), 0);
        check("rst_counter", int'(dut.counter), 9);
        check("rst_n_act", int'(dut.n_act), 10);

        mon_en = 1'b1;
        rst    = 1'b1;
        en     = 1'b1;
        wait_tick("first");
        check("first_counter", int'(dut.counter), 0);
        check("first_r_clk", int'(r_clk), 1);
        push_exp(10, 10, 0);

        // Table: ratio applied just after a wrap, so the following wrap samples it.
        for (int i = 0; i < 10; i++) begin
            div_ratio = 8'(vecs[i].div);
            for (int p = 0; p < vecs[i].periods; p++) begin
                push_exp(vecs[i].hi, vecs[i].lo, vecs[i].err);
            end
            for (int p = 0; p < vecs[i].periods; p++) begin
                wait_tick($sformatf("v%0d", i));
                if (p == 0) check($sformatf("v%0d_n_act", i), int'(dut.n_act), vecs[i].nact);
            end
        end

        // Mid-period ratio change 10 -> 4 at counter 3: current period stays 10.
        div_ratio = 8'd10;
        push_exp(10, 10, 0);
        wait_tick("midA");
        wait_counter(3, "midA");
        div_ratio = 8'd4;
        push_exp(4, 4, 0);
        push_exp(4, 4, 0);
        check("mid_n_act_held", int'(dut.n_act), 10);
        wait_tick("midB");
        check("mid_n_act_new", int'(dut.n_act), 4);
        wait_tick("midC");
        wait_tick("drain");
        check("sb_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset between edges while ratio_err and tick are high.
        div_ratio = 8'd1;
        wait_tick("err_setup");
        check("err_before_rst", int'(ratio_err), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_err", int'(ratio_err), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_n_act", int'(dut.n_act), 10);
        @(negedge clk);
        rst       = 1'b1;
        div_ratio = 8'd10;

        // Freeze for 7 cycles at counter 2 with r_clk high.
        wait_tick("en_setup");
        wait_counter(2, "en");
        check("en_r_clk_high", int'(r_clk), 1);
        en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("frz%0d_counter", c), int'(dut.counter), 2);
            check($sformatf("frz%0d_r_clk", c), int'(r_clk), 1);
            check($sformatf("frz%0d_tick", c), int'(tick), 0);
        end
        en     = 1'b1;
        hcount = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (r_clk !== 1'b1) break;
            hcount++;
        end
        check("resume_high_cycles", hcount, 3);

        // Reset between edges at counter 3: period truncated, no toggles while held.
        wait_counter(3, "rst");
        #2 rst = 1'b0;
        #1;
        check("trunc_r_clk", int'(r_clk), 0);
        check("trunc_tick", int'(tick), 0);
        check("trunc_ratio_err", int'(ratio_err), 0);
        check("trunc_counter", int'(dut.counter), 9);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_r_clk", int'(r_clk), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("release_r_clk", int'(r_clk), 1);
        check("release_tick", int'(tick), 1);
        check("release_counter", int'(dut.counter), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
